// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit sitting beside the ALU in EX.
// Latency: done_o N+3 cycles after an accepted start (N = XLEN/MUL_BPC for mul, XLEN for div); 2 cycles for div special cases.
// Backpressure: busy_o stalls F/D/E; start_i is ignored while busy; flush_i kills the op with no done_o.
module riscv_muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 1,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_BPC - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   opa_q, opb_q;
  logic [TAG_W-1:0]  tag_q;
  logic              neg_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic                    is_div, sign_a_en, sign_b_en, a_neg, b_neg;
  logic                    div_zero, div_ovf, special, accept, last, div_ge;
  logic [XLEN-1:0]         a_mag, b_mag, special_res, div_sel, fix_res;
  logic [MUL_BPC-1:0]      digit;
  logic [XLEN+MUL_BPC-1:0] pprod, msum;
  logic [XLEN:0]           dshift;
  logic [2*XLEN-1:0]       mul_nxt, div_nxt, prod;

  assign busy_o = (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
  assign done_o = (state == S_DONE);

  // Operand decode, special-case detection and the per-cycle mul/div step.
  always_comb begin
    is_div    = op_q[2];
    sign_a_en = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
    sign_b_en = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
    a_neg     = sign_a_en && opa_q[XLEN-1];
    b_neg     = sign_b_en && opb_q[XLEN-1];
    a_mag     = a_neg ? -opa_q : opa_q;
    b_mag     = b_neg ? -opb_q : opb_q;
    div_zero  = is_div && (opb_q == '0);
    div_ovf   = ((op_q == 3'b100) || (op_q == 3'b110)) && (opa_q == MOST_NEG) && (opb_q == '1);
    special   = div_zero || div_ovf;
    if (div_zero) special_res = op_q[1] ? opa_q : '1;
    else          special_res = op_q[1] ? '0 : opa_q;
    accept    = ((state == S_IDLE) || (state == S_DONE)) && start_i && !flush_i;
    last      = (cnt_q == (is_div ? DIV_LAST : MUL_LAST));
    // Multiply: add multiplicand times the low digit into the high half, shift right.
    digit     = acc_q[MUL_BPC-1:0];
    pprod     = {{MUL_BPC{1'b0}}, opa_q} * {{XLEN{1'b0}}, digit};
    msum      = {{MUL_BPC{1'b0}}, acc_q[2*XLEN-1:XLEN]} + pprod;
    mul_nxt   = {msum, acc_q[XLEN-1:MUL_BPC]};
    // Divide: remainder in the high half, dividend shifting out / quotient shifting in low.
    dshift    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = (dshift >= {1'b0, opb_q});
    div_nxt   = {div_ge ? XLEN'(dshift - {1'b0, opb_q}) : dshift[XLEN-1:0],
                 acc_q[XLEN-2:0], div_ge};
    // Final sign fix-up and result selection.
    prod      = neg_q ? -acc_q : acc_q;
    div_sel   = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (is_div)                 fix_res = neg_q ? -div_sel : div_sel;
    else if (op_q[1:0] == 2'b00) fix_res = prod[XLEN-1:0];
    else                        fix_res = prod[2*XLEN-1:XLEN];
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_PREP;
      S_PREP: state_nxt = special ? S_DONE : S_CALC;
      S_CALC: if (last) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = accept ? S_PREP : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush_i) state_nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Operand latch, iteration datapath and result/tag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      tag_q    <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_o <= '0;
      tag_o    <= '0;
    end else begin
      if (accept) begin
        op_q  <= op_i;
        opa_q <= a_i;
        opb_q <= b_i;
        tag_q <= tag_i;
      end
      if (!flush_i) begin
        case (state)
          S_PREP: begin
            opa_q <= a_mag;
            opb_q <= b_mag;
            neg_q <= (op_q == 3'b110) ? a_neg : (a_neg ^ b_neg);
            cnt_q <= '0;
            acc_q <= is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            if (special) begin
              result_o <= special_res;
              tag_o    <= tag_q;
            end
          end
          S_CALC: begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= is_div ? div_nxt : mul_nxt;
          end
          S_FIX: begin
            result_o <= fix_res;
            tag_o    <= tag_q;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/riscv_muldiv_unit.md
Name: riscv_muldiv_unit

Overview:
Iterative RV32M/RV64M multiply/divide unit that sits beside the ALU in the EX stage of the 5-stage pipeline.
- Accepts one operation per start pulse and holds busy high so the hazard unit stalls F/D/E.
- Returns the result with its destination-register tag when done, for the EX/MEM register.
- Generalised over XLEN and multiplier radix; supports kill on EX flush.

Parameters:
XLEN, 32, operand/result width (32 or 64)
MUL_BPC, 1, multiplier bits retired per CALC cycle (1, 2 or 4; must divide XLEN)
TAG_W, 5, width of passthrough tag (rd index)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
start_i  in  1  request new op; sampled only in IDLE or DONE
flush_i  in  1  kill in-flight op (driven by flush_e)
op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a_i  in  XLEN  rs1 operand
b_i  in  XLEN  rs2 operand
tag_i  in  TAG_W  rd tag, captured with start
busy_o  out  1  high in PREP, CALC, FIX
done_o  out  1  one-cycle pulse, result valid
result_o  out  XLEN  result; held until next accepted start
tag_o  out  TAG_W  tag captured at accepted start

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; busy_o=0, done_o=0, result_o=0, tag_o=0, counter=0. Applies mid-operation; the op is discarded with no done.
- States: IDLE, PREP, CALC, FIX, DONE.
  - IDLE/DONE + start_i & !flush_i -> PREP. Latch op, a, b, tag.
  - DONE with no start -> IDLE.
- PREP (1 cycle):
  - Record result sign. Replace signed operands with their magnitudes. Signed per op: MULH both; MULHSU a only; DIV/REM both; others unsigned.
  - Special cases skip CALC/FIX and go to DONE:
    - div-by-zero: DIV/DIVU -> all ones; REM/REMU -> a.
    - signed overflow (a = most-negative, b = -1): DIV -> a; REM -> 0.
  - Otherwise -> CALC, counter cleared.
- CALC, multiply:
  - Shift-add over a 2*XLEN accumulator, MUL_BPC bits per cycle.
  - N = XLEN/MUL_BPC cycles.
- CALC, divide:
  - Restoring division, 1 quotient bit per cycle.
  - N = XLEN cycles.
- CALC exit: -> FIX when counter = N-1.
- FIX (1 cycle):
  - Two's-complement negate if the sign flag is set. Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
  - Select the result: MUL = low XLEN bits; MULH* = high XLEN bits; DIV* = quotient; REM* = remainder.
  - -> DONE.
- DONE: done_o=1 for exactly this cycle; result_o/tag_o valid.
- Latency, start high in cycle 0:
  - Normal op: done_o in cycle N+3; busy_o high cycles 1..N+2.
  - Special case: done_o in cycle 2; busy_o high in cycle 1 only.
- start_i while busy_o=1: ignored. No state change, operands not re-latched.
- flush_i=1 in any state: next state IDLE, no done_o. result_o/tag_o keep their previous values.
- flush_i and start_i high in the same cycle: flush wins, start is dropped.
- Back-to-back: start in the DONE cycle is accepted; the next cycle is PREP.
- All arithmetic is modulo 2^XLEN per RISC-V M spec. No X propagation: unused accumulator bits are reset to 0.

Test Plan:
- XLEN=32, MUL_BPC=1, start in cycle 0: MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done_o in cycle 35 only, busy_o high cycles 1-34; tag_i=5 -> tag_o=5.
- High-half multiplies:
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE
  - MULH 0x80000000*0x80000000 -> 0x40000000
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF
- Divides, back-to-back starts issued in the DONE cycle, each done 35 cycles after its start:
  - DIV -7/2 -> 0xFFFFFFFD
  - REM -7/2 -> 0xFFFFFFFF
  - DIVU 100/7 -> 14
  - REMU 100/7 -> 2
- Corner cases, each done_o in cycle 2:
  - DIV 5/0 -> 0xFFFFFFFF
  - REMU 5/0 -> 5
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
  - REM same operands -> 0
- Flush and start interaction:
  - flush_i pulse in cycle 12 of a MUL -> busy_o=0 in cycle 13, no done_o, result_o unchanged.
  - start_i+flush_i together -> not accepted.
  - start_i while busy -> ignored, original result returned.
- MUL_BPC=4, XLEN=64: MUL 0x123456789*0x10 -> 0x1234567890, done_o in cycle 19. rst_n low in cycle 8 -> all outputs 0 in cycle 9, no done_o.
